// File: rtl/clk_div_multi.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | clk_div_multi : CHANNELS independent half-period clock dividers with a       |
// |                 shared sync strobe. Optional macro CLKDIV_SHADOW_EN latches  |
// |                 each divisor at reset, sync and wrap instead of using it live.|
// | Revision      : 1.0 - initial release                                        |
// +-----------------------------------------------------------------------------+
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*CNT_W-1:0] div_max,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       div_clk,
  output logic [CHANNELS-1:0]       tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim;
    logic [CNT_W-1:0] lim_in;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             wrap;

    assign lim_in = div_max[i*CNT_W +: CNT_W];

`ifdef CLKDIV_SHADOW_EN
    logic [CNT_W-1:0] lim_q;

    // Divisor is only picked up at period boundaries so no half-period is cut short.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lim_q <= lim_in;
      end else if (sync || wrap) begin
        lim_q <= lim_in;
      end
    end

    assign lim = lim_q;
`else
    assign lim = lim_in;
`endif

    // >= rather than == so a divisor lowered below cnt wraps immediately.
    assign wrap = en[i] && (cnt_q >= lim);

    always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      if (sync) begin
        cnt_d = '0;
        div_d = 1'b0;
      end else if (en[i]) begin
        if (wrap) begin
          cnt_d  = '0;
          div_d  = ~div_q;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        div_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        tick_q <= tick_d;
      end
    end

    assign div_clk[i] = div_q;
    assign tick[i]    = tick_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// Testbench for clk_div_multi: vector table plus scoreboarded hand sequences.
module tb_clk_div_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sync;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] div_max;
  logic [CH-1:0]   div_clk;
  logic [CH-1:0]   tick;

  always #5 clk = ~clk;

  clk_div_multi #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_max (div_max),
    .sync    (sync),
    .div_clk (div_clk),
    .tick    (tick)
  );

  typedef struct packed {
    logic [CH-1:0] e_clk;
    logic [CH-1:0] e_tick;
  } exp_t;

  typedef struct {
    logic            rst_n;
    logic            sync;
    logic [CH-1:0]   en;
    logic [CH*W-1:0] dm;
    logic [CH-1:0]   e_clk;
    logic [CH-1:0]   e_tick;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[12];

  int errors = 0;
  int checks = 0;

  logic [W-1:0]  m_cnt[CH];
  logic [CH-1:0] m_clk;
  logic [CH-1:0] m_tick;
`ifdef CLKDIV_SHADOW_EN
  logic [W-1:0]  m_lim[CH];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model with the currently driven inputs, then one clock, then score.
  task automatic step();
    exp_t e;
    for (int i = 0; i < CH; i++) begin
      logic [W-1:0] sl;
      logic [W-1:0] lim;
      sl = div_max[i*W +: W];
`ifdef CLKDIV_SHADOW_EN
      lim = m_lim[i];
`else
      lim = sl;
`endif
      if (!rst_n || sync) begin
        m_cnt[i]  = '0;
        m_clk[i]  = 1'b0;
        m_tick[i] = 1'b0;
`ifdef CLKDIV_SHADOW_EN
        m_lim[i]  = sl;
`endif
      end else if (en[i]) begin
        if (m_cnt[i] >= lim) begin
          m_cnt[i]  = '0;
          m_clk[i]  = ~m_clk[i];
          m_tick[i] = 1'b1;
`ifdef CLKDIV_SHADOW_EN
          m_lim[i]  = sl;
`endif
        end else begin
          m_cnt[i]  = m_cnt[i] + 1'b1;
          m_tick[i] = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
    end
    sb.push_back('{e_clk: m_clk, e_tick: m_tick});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_div_clk", 32'(div_clk), 32'(e.e_clk));
    chk("sb_tick", 32'(tick), 32'(e.e_tick));
  endtask

  // Step until tick[ch] rises; n returns the number of edges (budget on timeout).
  task automatic wait_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick[ch] && n < budget);
  endtask

  initial begin
    logic [CH*W-1:0] dm2;
    logic [CH*W-1:0] dm_ch0z;
    int n;

    dm2     = {CH{8'd2}};
    dm_ch0z = {8'd2, 8'd2, 8'd2, 8'd0};

    tbl[0]  = '{1'b0, 1'b0, 4'hF, dm2,     4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'hF, dm2,     4'h0, 4'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'hF, dm2,     4'h0, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 4'hF, dm2,     4'hF, 4'hF};
    tbl[4]  = '{1'b1, 1'b0, 4'hF, dm2,     4'hF, 4'h0};
    tbl[5]  = '{1'b1, 1'b0, 4'hF, dm2,     4'hF, 4'h0};
    tbl[6]  = '{1'b1, 1'b0, 4'hF, dm2,     4'h0, 4'hF};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, dm2,     4'h0, 4'h0};
    tbl[8]  = '{1'b1, 1'b1, 4'hF, dm2,     4'h0, 4'h0};
    tbl[9]  = '{1'b1, 1'b0, 4'h1, dm_ch0z, 4'h1, 4'h1};
    tbl[10] = '{1'b1, 1'b0, 4'h1, dm_ch0z, 4'h0, 4'h1};
    tbl[11] = '{1'b1, 1'b0, 4'h0, dm_ch0z, 4'h0, 4'h0};

    rst_n   = 1'b0;
    sync    = 1'b0;
    en      = '0;
    div_max = dm2;

    for (int k = 0; k < 12; k++) begin
      rst_n   = tbl[k].rst_n;
      sync    = tbl[k].sync;
      en      = tbl[k].en;
      div_max = tbl[k].dm;
      step();
      chk($sformatf("vec%0d_div_clk", k), 32'(div_clk), 32'(tbl[k].e_clk));
      chk($sformatf("vec%0d_tick", k), 32'(tick), 32'(tbl[k].e_tick));
    end

    // Channel 1 paused for 5 cycles at cnt=4: toggle 5 cycles late.
    div_max = {8'd2, 8'd2, 8'd9, 8'd2};
    en = 4'b0010; sync = 1'b1; step(); sync = 1'b0;
    repeat (4) step();
    en = 4'b0000;
    repeat (5) step();
    chk("pause_hold_div_clk1", 32'(div_clk[1]), 32'd0);
    en = 4'b0010;
    wait_tick(1, 20, n);
    chk("pause_first_toggle", n, 6);
    chk("pause_div_clk1_high", 32'(div_clk[1]), 32'd1);
    wait_tick(1, 20, n);
    chk("pause_half_period", n, 10);

    // Two channels out of phase, then realigned by sync.
    div_max = {8'd2, 8'd2, 8'd5, 8'd3};
    en = 4'b0011;
    repeat (7) step();
    sync = 1'b1; step(); sync = 1'b0;
    chk("sync_div_clk_zero", 32'(div_clk), 32'd0);
    chk("sync_tick_zero", 32'(tick), 32'd0);
    wait_tick(0, 20, n);
    chk("sync_ch0_first_rise", n, 4);
    wait_tick(1, 20, n);
    chk("sync_ch1_first_rise", n, 2);

    // Channel 2 divisor lowered from 9 to 2 at cnt=6.
    div_max = {8'd2, 8'd9, 8'd2, 8'd2};
    en = 4'b0100; sync = 1'b1; step(); sync = 1'b0;
    repeat (6) step();
    div_max = {8'd2, 8'd2, 8'd2, 8'd2};
    wait_tick(2, 20, n);
`ifdef CLKDIV_SHADOW_EN
    chk("lower_div_wrap", n, 4);
`else
    chk("lower_div_wrap", n, 1);
`endif
    wait_tick(2, 20, n);
    chk("lower_div_next_half", n, 3);

    // Reset pulse mid-period.
    div_max = dm2;
    en = 4'hF; sync = 1'b1; step(); sync = 1'b0;
    repeat (4) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("midrst_div_clk", 32'(div_clk), 32'd0);
    chk("midrst_tick", 32'(tick), 32'd0);
    wait_tick(0, 20, n);
    chk("midrst_first_toggle", n, 3);
    chk("midrst_div_clk_all", 32'(div_clk), 32'hF);

    // Reset asserted and released between clock edges must not change state.
    rst_n = 1'b0;
    #2;
    chk("rst_no_edge_div_clk", 32'(div_clk), 32'hF);
    chk("rst_no_edge_tick", 32'(tick), 32'hF);
    rst_n = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
